performance_prog_avg_calc: RTL
==============================

Name: performance_prog_avg_calc

Overview:
- Downstream consumer of the per-channel program latency counter.
- When the counter raises its ready flag, this block:
  - captures the accumulated program-cycle sum and the completed-request count;
  - computes the average program latency with a multi-cycle restoring divider;
  - publishes the result to the slave register file;
  - returns the one-cycle copy-complete pulse that lets the counter clear its sum and count and re-arm.

Parameters:
- CNT_WD, 32, width of the accumulated cycle sum and of the average result.
- REQ_WD, 10, width of the request count (divisor).

Ports:
- i_bus_clk  input  1  bus clock; all logic on rising edge.
- i_bus_rst  input  1  synchronous, active-high reset.
- i_prog_ready  input  1  counter has a frozen sum and count (level; high while the counter is in its copy-complete wait).
- i_prog_cnt  input  CNT_WD  accumulated program cycles.
- i_prog_req_cnt  input  REQ_WD  number of completed, non-failed programs.
- o_prog_cnt_cp_cmplt  output  1  one-cycle pulse: snapshot consumed, counter may clear.
- o_avg_lat  output  CNT_WD  last computed average latency, in bus cycles.
- o_avg_req_cnt  output  REQ_WD  request count used for o_avg_lat.
- o_avg_valid  output  1  sticky: new result not yet read by host.
- i_avg_rd  input  1  host read strobe; clears o_avg_valid.
- o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous): state IDLE; every output and internal register is 0.
- Reset mid-division abandons the operation. No cp_cmplt pulse is issued; o_avg_lat returns to 0.
- States:
  - IDLE: if i_prog_ready=1, latch sum into dividend and count into divisor, go to DIV. If the latched count is 0, go to DONE instead with quotient forced to 0.
  - DIV: restoring division, one quotient bit per cycle, MSB first, exactly CNT_WD cycles.
    - Partial remainder is REQ_WD+1 bits.
    - Each cycle: shift the next dividend bit in, trial-subtract the divisor, keep the difference if non-negative and set the quotient bit to 1.
    - After CNT_WD cycles, go to DONE.
  - DONE (1 cycle):
    - o_avg_lat <= quotient;
    - o_avg_req_cnt <= latched count;
    - o_avg_valid <= 1;
    - o_prog_cnt_cp_cmplt = 1 (registered, high exactly this cycle);
    - go to WAIT.
  - WAIT: remain until i_prog_ready=0, then go to IDLE. This prevents a re-capture while the upstream ready is still deasserting; upstream ready lags its state by 2 cycles.
- Latency: capture cycle = T. DONE is at T+CNT_WD+1 (T+33 by default), or T+1 when the count is 0.
- o_avg_lat / o_avg_req_cnt hold their value until the next DONE. They are never cleared by i_avg_rd.
- o_avg_valid:
  - set in DONE;
  - cleared on i_avg_rd;
  - if DONE and i_avg_rd coincide, set wins (stays 1).
- Arithmetic: the quotient fits CNT_WD, so no overflow is possible. The remainder is discarded unless the optional feature is enabled.
- Inputs are sampled only in the IDLE capture cycle. Changes during DIV are ignored.

Optional Feature:
- Macro PERF_AVG_ROUND_EN.
- Defined: DONE adds 1 to the quotient when 2*remainder >= divisor (round half up).
  - This cannot overflow: an all-ones quotient implies divisor 1 and remainder 0.
  - Count 0 still yields 0.
- Undefined: truncating division; the rounding logic is not elaborated.

Decomposition:
- p_parameter.vh carries:
  - state encodings (IDLE 2'b00, DIV 2'b01, DONE 2'b11, WAIT 2'b10);
  - SLV_DATA_WD, used as the CNT_WD default.
- One sub-module, perf_seq_divider, contains the restoring divider:
  - ports: start, dividend, divisor, done, quotient, remainder;
  - parameterised by CNT_WD / REQ_WD.
- Top level owns the FSM, handshake and output registers.

Test Plan:
- Sum 25000, count 10, ready held high → cp_cmplt pulses once at T+33; o_avg_lat=2500, o_avg_req_cnt=10, o_avg_valid=1.
- Count 0, sum 0, ready high → cp_cmplt at T+1; o_avg_lat=0; no divide cycles.
- Sum 7, count 2 → o_avg_lat=3 without PERF_AVG_ROUND_EN, 4 with it. Sum 32'hFFFFFFFF, count 1 → 32'hFFFFFFFF in both builds.
- Ready held high 5 cycles after the pulse, then a low→high re-assertion with sum 100, count 4 → exactly one pulse per assertion; second result 25.
- Assert i_bus_rst at cycle T+10 of a divide → next cycle state IDLE, all outputs 0; no cp_cmplt pulse until a fresh ready.
- i_avg_rd in the same cycle as DONE → o_avg_valid stays 1. i_avg_rd one cycle later → 0, and o_avg_lat is unchanged.

Source files
------------

// File: rtl/performance_prog_avg_calc_pkg.sv
// ---------------------------------------------------------------------------
// performance_prog_avg_calc_pkg
// Shared definitions for the program-latency averaging block:
//   - state_e     : FSM state encoding (IDLE/DIV/DONE/WAIT)
//   - SLV_DATA_WD : slave register data width, default width of the cycle sum
// ---------------------------------------------------------------------------
package performance_prog_avg_calc_pkg;

    localparam int SLV_DATA_WD = 32;

    // Fixed encoding so the state value is stable for debug visibility.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DIV  = 2'b01,
        ST_DONE = 2'b11,
        ST_WAIT = 2'b10
    } state_e;

endpackage

// File: rtl/performance_prog_avg_calc_perf_seq_divider.sv
// ---------------------------------------------------------------------------
// perf_seq_divider
// Sequential restoring divider, one quotient bit per cycle, MSB first,
// exactly CNT_WD iteration cycles after the start cycle.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i           load dividend/divisor and begin (divisor must be != 0)
//   dividend_i        CNT_WD-bit dividend
//   divisor_i         REQ_WD-bit divisor
//   done_o            high during the final iteration cycle; quotient_o and
//                     remainder_o are final from the following cycle on
//   quotient_o        CNT_WD-bit quotient (held until the next start)
//   remainder_o       REQ_WD+1-bit partial remainder (final remainder at end)
// ---------------------------------------------------------------------------
module perf_seq_divider #(
    parameter int CNT_WD = 32,
    parameter int REQ_WD = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [CNT_WD-1:0] dividend_i,
    input  logic [REQ_WD-1:0] divisor_i,
    output logic              done_o,
    output logic [CNT_WD-1:0] quotient_o,
    output logic [REQ_WD:0]   remainder_o
);

    localparam int CW = $clog2(CNT_WD + 1);

    logic [CNT_WD-1:0] dvd_q;
    logic [REQ_WD-1:0] dvs_q;
    logic [REQ_WD:0]   rem_q;
    logic [CNT_WD-1:0] quo_q;
    logic [CW-1:0]     cnt_q;

    logic [REQ_WD:0]   rem_shift_d;
    logic [REQ_WD+1:0] diff_d;

    // The stored remainder is always below the divisor, so its top bit is
    // zero and dropping it before the shift loses nothing.
    // NOTE: always_comb assigns every output on every path, so no latch is inferred.
    always_comb begin
        rem_shift_d = {rem_q[REQ_WD-1:0], dvd_q[CNT_WD-1]};
        diff_d      = {1'b0, rem_shift_d} - {2'b00, dvs_q};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            dvd_q <= dividend_i;
            dvs_q <= divisor_i;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= CW'(CNT_WD);
        end else if (cnt_q != '0) begin
            dvd_q <= dvd_q << 1;
            cnt_q <= cnt_q - CW'(1);
            // Sign bit of the trial difference: set means it went negative.
            if (!diff_d[REQ_WD+1]) begin
                rem_q <= diff_d[REQ_WD:0];
                quo_q <= {quo_q[CNT_WD-2:0], 1'b1};
            end else begin
                rem_q <= rem_shift_d;
                quo_q <= {quo_q[CNT_WD-2:0], 1'b0};
            end
        end
    end

    assign done_o      = (cnt_q == CW'(1));
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/performance_prog_avg_calc.sv
// ---------------------------------------------------------------------------
// performance_prog_avg_calc
// Consumes a frozen program-cycle sum and request count from the per-channel
// latency counter, computes the average latency with a sequential divider,
// publishes it to the register file and returns a copy-complete pulse.
// Optional build macro: PERF_AVG_ROUND_EN (round half up instead of truncate).
// Ports:
//   i_bus_clk, i_bus_rst   clock, synchronous active-high reset
//   i_prog_ready           counter snapshot available (level)
//   i_prog_cnt             accumulated program cycles (dividend)
//   i_prog_req_cnt         completed request count (divisor)
//   o_prog_cnt_cp_cmplt    one-cycle pulse: snapshot consumed
//   o_avg_lat              last average latency in bus cycles
//   o_avg_req_cnt          request count behind o_avg_lat
//   o_avg_valid            sticky new-result flag, cleared by i_avg_rd
//   i_avg_rd               host read strobe
//   o_busy                 FSM not in IDLE
// ---------------------------------------------------------------------------
module performance_prog_avg_calc
    import performance_prog_avg_calc_pkg::*;
#(
    parameter int CNT_WD = SLV_DATA_WD,
    parameter int REQ_WD = 10
) (
    input  logic              i_bus_clk,
    input  logic              i_bus_rst,
    input  logic              i_prog_ready,
    input  logic [CNT_WD-1:0] i_prog_cnt,
    input  logic [REQ_WD-1:0] i_prog_req_cnt,
    output logic              o_prog_cnt_cp_cmplt,
    output logic [CNT_WD-1:0] o_avg_lat,
    output logic [REQ_WD-1:0] o_avg_req_cnt,
    output logic              o_avg_valid,
    input  logic              i_avg_rd,
    output logic              o_busy
);

    state_e            state_q;
    logic [REQ_WD-1:0] req_q;
    logic              cp_cmplt_q;
    logic [CNT_WD-1:0] avg_lat_q;
    logic [REQ_WD-1:0] avg_req_q;
    logic              valid_q;

    logic              div_start;
    logic              div_done;
    logic [CNT_WD-1:0] div_quot;
    logic [REQ_WD:0]   div_rem;
    logic [CNT_WD-1:0] result_d;

    // A zero count bypasses the divider entirely.
    assign div_start = (state_q == ST_IDLE) && i_prog_ready && (i_prog_req_cnt != '0);

    perf_seq_divider #(
        .CNT_WD (CNT_WD),
        .REQ_WD (REQ_WD)
    ) u_div (
        .clk_i       (i_bus_clk),
        .rst_i       (i_bus_rst),
        .start_i     (div_start),
        .dividend_i  (i_prog_cnt),
        .divisor_i   (i_prog_req_cnt),
        .done_o      (div_done),
        .quotient_o  (div_quot),
        .remainder_o (div_rem)
    );

`ifdef PERF_AVG_ROUND_EN
    // Round half up; an all-ones quotient only occurs with divisor 1 and
    // remainder 0, so the increment cannot wrap.
    logic round_up;
    assign round_up = ({div_rem, 1'b0} >= {2'b00, req_q});
    assign result_d = (req_q == '0) ? '0 : div_quot + CNT_WD'(round_up);
`else
    logic unused_rem;
    assign unused_rem = ^div_rem;
    assign result_d   = (req_q == '0) ? '0 : div_quot;
`endif

    always_ff @(posedge i_bus_clk) begin
        if (i_bus_rst) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            cp_cmplt_q <= 1'b0;
            avg_lat_q  <= '0;
            avg_req_q  <= '0;
            valid_q    <= 1'b0;
        end else begin
            cp_cmplt_q <= 1'b0;
            // Read clears; the DONE branch below overrides so set wins.
            if (i_avg_rd) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_prog_ready) begin
                        req_q <= i_prog_req_cnt;
                        if (i_prog_req_cnt == '0) begin
                            state_q    <= ST_DONE;
                            cp_cmplt_q <= 1'b1;
                        end else begin
                            state_q <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    // Entering DONE raises the pulse so it is high for the DONE cycle.
                    if (div_done) begin
                        state_q    <= ST_DONE;
                        cp_cmplt_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    avg_lat_q <= result_d;
                    avg_req_q <= req_q;
                    valid_q   <= 1'b1;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Upstream ready lags by two cycles; wait for it to drop.
                    if (!i_prog_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_prog_cnt_cp_cmplt = cp_cmplt_q;
    assign o_avg_lat           = avg_lat_q;
    assign o_avg_req_cnt       = avg_req_q;
    assign o_avg_valid         = valid_q;
    assign o_busy              = (state_q != ST_IDLE);

endmodule
